i2c_target_regs: RTL and testbench

- I2C responder (target) for the 8-bit-register / 8-bit-data / 7-bit-address transactions the hsdaoh I2C master issues.
- Exposes a simple synchronous register-access port, so on-FPGA settings can be read and written over I2C.
- Sits beside the settings logic in the FPGA top; I2C pins come straight from the board.
- Fixed 100/400 kHz standard protocol: no clock stretching, no general call, no 10-bit addressing.

---
 rtl/i2c_target_regs_pkg.sv | 29 ++
 rtl/i2c_target_regs_line_filter.sv | 61 ++++++
 rtl/i2c_target_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regs_pkg.sv
// I2C register target: shared state encoding and protocol constants.
// Imported by the line filter and the protocol engine.
package i2c_target_regs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REG,
    WDATA,
    RDATA,
    ACK_OUT,
    ACK_IN,
    IGNORE
  } state_t;

  localparam logic I2C_RW_READ = 1'b1;

  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_DONE = 4'd8;
  localparam logic [3:0] ACK_SEEN = 4'd1;

  function automatic logic addr_hit(
    input logic [7:0] byte_i,
    input logic [6:0] dev_i
  );
    return byte_i[7:1] == dev_i;
  endfunction

endpackage

// File: rtl/i2c_target_regs_line_filter.sv
// I2C line conditioner: 2-FF synchronizer, run-length glitch filter,
// and single-cycle rise/fall pulses aligned with the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[0], line_i};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
        fall_d  = !sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target mapping 8-bit register reads/writes onto a simple
// synchronous register port; SDA is open-drain, SCL is never driven.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h48,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_scl (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (i2c_scl),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sda (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (i2c_sda),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_evt, stop_evt;

  assign start_evt = sda_fall & scl_lvl;
  assign stop_evt  = sda_rise & scl_lvl;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       inc_q, inc_d;
  logic [7:0] byte_in;
  logic       last_bit;
  logic       load_rd;

  assign byte_in  = {shift_q[6:0], sda_lvl};
  assign last_bit = scl_rise && (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = inc_q ? addr_q + 8'd1 : addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    inc_d   = 1'b0;
    load_rd = 1'b0;
    unique case (1'b1)
      start_evt: begin
        state_d = ADDR;
        cnt_d   = '0;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
      end
      stop_evt: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
      end
      default: begin
        unique case (state_q)
          IDLE, IGNORE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shift_d = byte_in;
              cnt_d   = cnt_q + 4'd1;
            end
            if (last_bit) begin
              cnt_d = '0;
              if (addr_hit(byte_in, DEVICE_ADDR)) begin
                busy_d  = 1'b1;
                state_d = ACK_OUT;
                ret_d   = (byte_in[0] == I2C_RW_READ) ? RDATA : REG;
              end else begin
                state_d = IGNORE;
              end
            end
          end
          REG: begin
            if (scl_rise) begin
              shift_d = byte_in;
              cnt_d   = cnt_q + 4'd1;
            end
            if (last_bit) begin
              cnt_d   = '0;
              addr_d  = byte_in;
              state_d = ACK_OUT;
              ret_d   = WDATA;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift_d = byte_in;
              cnt_d   = cnt_q + 4'd1;
            end
            if (last_bit) begin
              cnt_d   = '0;
              wdata_d = byte_in;
              we_d    = 1'b1;
              inc_d   = 1'b1;
              state_d = ACK_OUT;
              ret_d   = WDATA;
            end
          end
          // First fall after bit 8 pulls SDA low, the next one ends the ACK.
          ACK_OUT: begin
            if (scl_fall) begin
              if (!oe_q) begin
                oe_d = 1'b1;
              end else if (ret_q == RDATA) begin
                load_rd = 1'b1;
              end else begin
                oe_d    = 1'b0;
                cnt_d   = '0;
                state_d = ret_q;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              cnt_d = cnt_q + 4'd1;
            end
            if (scl_fall) begin
              if (cnt_q == BIT_DONE) begin
                oe_d    = 1'b0;
                cnt_d   = '0;
                state_d = ACK_IN;
              end else begin
                shift_d = {shift_q[6:0], 1'b0};
                oe_d    = !shift_q[6];
              end
            end
          end
          ACK_IN: begin
            if (scl_rise) begin
              if (sda_lvl) begin
                state_d = IGNORE;
              end else begin
                cnt_d = ACK_SEEN;
              end
            end
            if (scl_fall && cnt_q == ACK_SEEN) begin
              load_rd = 1'b1;
            end
          end
        endcase
      end
    endcase
    if (load_rd) begin
      re_d    = 1'b1;
      shift_d = reg_rdata;
      oe_d    = !reg_rdata[7];
      inc_d   = 1'b1;
      cnt_d   = '0;
      state_d = RDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      re_q    <= re_d;
      inc_q   <= inc_d;
    end
  end

  assign i2c_sda   = oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master at ~400 kHz
// against a 27 MHz-class clock, with strobe logging on the register port.
module tb_i2c_target_regs;

  localparam int Q = 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  int checks = 0;
  int errors = 0;
  int we_n = 0;
  int re_n = 0;
  int both_n = 0;
  int drove_n = 0;
  int busy_n = 0;
  logic [7:0] we_addr [16];
  logic [7:0] we_data [16];

  pullup (sda_bus);
  assign sda_bus   = m_sda_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ 8'hFF;

  always #18 clk = ~clk;

  i2c_target_regs #(
    .DEVICE_ADDR(7'h48),
    .FILTER_LEN (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2c_scl  (scl),
    .i2c_sda  (sda_bus),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr[we_n % 16] <= reg_addr;
      we_data[we_n % 16] <= reg_wdata;
      we_n <= we_n + 1;
    end
    if (reg_re) re_n <= re_n + 1;
    if (reg_we && reg_re) both_n <= both_n + 1;
    if (sda_bus === 1'b0 && !m_sda_low) drove_n <= drove_n + 1;
    if (busy) busy_n <= busy_n + 1;
  end

  task automatic wq(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wq(1);
    scl = 1'b1; wq(1);
    m_sda_low = 1'b1; wq(1);
    scl = 1'b0; wq(1);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wq(1);
    scl = 1'b1; wq(1);
    m_sda_low = 1'b0; wq(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda_low = !b[i]; wq(1);
      scl = 1'b1; wq(2);
      scl = 1'b0; wq(1);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_sda_low = 1'b0; wq(1);
    scl = 1'b1; wq(1);
    ack = (sda_bus === 1'b0); wq(1);
    scl = 1'b0; wq(1);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = 1'b0; wq(1);
      scl = 1'b1; wq(1);
      b[i] = (sda_bus !== 1'b0); wq(1);
      scl = 1'b0; wq(1);
    end
    m_sda_low = !nack; wq(1);
    scl = 1'b1; wq(2);
    scl = 1'b0; wq(1);
    m_sda_low = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_addr, reg_wdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: got %h expected 0000", {reg_addr, reg_wdata});
    end
    checks++;
    if ({reg_we, reg_re, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000", {reg_we, reg_re, busy});
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_sda: got %b expected 1", sda_bus);
    end
    rst_n = 1'b1;
    wq(1);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int w0;
    w0 = we_n;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h05, a1);
    write_byte(8'hA5, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++;
      $display("FAIL write_acks: got %b expected 111", {a0, a1, a2});
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL write_busy: got %b expected 1", busy);
    end
    bus_stop();
    wq(1);
    checks++;
    if (we_n - w0 !== 1) begin
      errors++;
      $display("FAIL write_we_count: got %0d expected 1", we_n - w0);
    end
    checks++;
    if ({we_addr[w0 % 16], we_data[w0 % 16]} !== 16'h05A5) begin
      errors++;
      $display("FAIL write_strobe: got %h expected 05a5",
               {we_addr[w0 % 16], we_data[w0 % 16]});
    end
    checks++;
    if (reg_addr !== 8'h06) begin
      errors++;
      $display("FAIL write_ptr_inc: got %h expected 06", reg_addr);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_stop: got %b expected 0", busy);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h33};
    logic [4:0] acks;
    int w0;
    w0 = we_n;
    bus_start();
    write_byte(8'h90, acks[0]);
    write_byte(8'hFE, acks[1]);
    write_byte(8'h11, acks[2]);
    write_byte(8'h22, acks[3]);
    write_byte(8'h33, acks[4]);
    bus_stop();
    wq(1);
    checks++;
    if (acks !== 5'b11111) begin
      errors++;
      $display("FAIL burst_acks: got %b expected 11111", acks);
    end
    checks++;
    if (we_n - w0 !== 3) begin
      errors++;
      $display("FAIL burst_we_count: got %0d expected 3", we_n - w0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({we_addr[(w0 + i) % 16], we_data[(w0 + i) % 16]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL burst_strobe%0d: got %h expected %h", i,
                 {we_addr[(w0 + i) % 16], we_data[(w0 + i) % 16]}, {ea[i], ed[i]});
      end
    end
    checks++;
    if (reg_addr !== 8'h01) begin
      errors++;
      $display("FAIL burst_wrap_ptr: got %h expected 01", reg_addr);
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    int r0;
    r0 = re_n;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h10, a1);
    bus_start();
    write_byte(8'h91, a2);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL read_release: got %b expected 1", sda_bus);
    end
    bus_stop();
    wq(1);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      errors++;
      $display("FAIL read_acks: got %b expected 111", {a0, a1, a2});
    end
    checks++;
    if ({b0, b1} !== 16'hEFEE) begin
      errors++;
      $display("FAIL read_bytes: got %h expected efee", {b0, b1});
    end
    checks++;
    if (re_n - r0 !== 2) begin
      errors++;
      $display("FAIL read_re_count: got %0d expected 2", re_n - r0);
    end
    checks++;
    if (reg_addr !== 8'h12) begin
      errors++;
      $display("FAIL read_ptr: got %h expected 12", reg_addr);
    end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int w0, r0, d0, b0;
    w0 = we_n; r0 = re_n; d0 = drove_n; b0 = busy_n;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(8'h00, a1);
    bus_stop();
    wq(1);
    checks++;
    if ({a0, a1} !== 2'b00) begin
      errors++;
      $display("FAIL wrong_acks: got %b expected 00", {a0, a1});
    end
    checks++;
    if ((we_n - w0) + (re_n - r0) !== 0) begin
      errors++;
      $display("FAIL wrong_strobes: got %0d expected 0", (we_n - w0) + (re_n - r0));
    end
    checks++;
    if (drove_n - d0 !== 0) begin
      errors++;
      $display("FAIL wrong_sda_driven: got %0d expected 0", drove_n - d0);
    end
    checks++;
    if (busy_n - b0 !== 0) begin
      errors++;
      $display("FAIL wrong_busy: got %0d expected 0", busy_n - b0);
    end
  endtask

  task automatic test_glitch();
    logic a0;
    bus_start();
    write_byte(8'h90, a0);
    scl = 1'b1; wq(1);
    m_sda_low = 1'b1;
    repeat (2) @(negedge clk);
    m_sda_low = 1'b0;
    wq(1);
    checks++;
    if ({a0, busy} !== 2'b11) begin
      errors++;
      $display("FAIL glitch_short: got %b expected 11", {a0, busy});
    end
    m_sda_low = 1'b1;
    repeat (4) @(negedge clk);
    m_sda_low = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_long_start: got %b expected 0", busy);
    end
    wq(1);
  endtask

  task automatic test_abort_reset();
    logic a0, a1;
    int w0;
    w0 = we_n;
    bus_start();
    write_byte(8'h90, a0);
    write_byte(8'h07, a1);
    send_bits(8'hA0, 4);
    bus_stop();
    wq(1);
    checks++;
    if (we_n - w0 !== 0) begin
      errors++;
      $display("FAIL abort_no_we: got %0d expected 0", we_n - w0);
    end
    checks++;
    if ({a0, a1, reg_addr} !== {2'b11, 8'h07}) begin
      errors++;
      $display("FAIL abort_ptr: got %b_%h expected 11_07", {a0, a1}, reg_addr);
    end
    bus_start();
    send_bits(8'h90, 8);
    m_sda_low = 1'b0;
    wq(1);
    checks++;
    if ({sda_bus, busy} !== 2'b01) begin
      errors++;
      $display("FAIL rst_pre_ack: got %b expected 01", {sda_bus, busy});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL rst_sda_release: got %b expected 1", sda_bus);
    end
    checks++;
    if ({reg_addr, reg_wdata, reg_we, reg_re, busy} !== 19'd0) begin
      errors++;
      $display("FAIL rst_outputs: got %h expected 0",
               {reg_addr, reg_wdata, reg_we, reg_re, busy});
    end
    wq(1);
    scl = 1'b1; wq(1);
    rst_n = 1'b1; wq(1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_wrap();
    test_read();
    test_wrong_addr();
    test_glitch();
    test_abort_reset();
    checks++;
    if (both_n !== 0) begin
      errors++;
      $display("FAIL we_re_overlap: got %0d expected 0", both_n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
